// File: rtl/write_resp_channel_arb.sv
// rtl/write_resp_channel_arb.sv - round-robin B-channel arbiter with a single-entry registered output stage
module write_resp_channel_arb #(
    parameter int Num_Of_Slaves   = 4,
    parameter int Num_Of_Masters  = 4,
    parameter int Master_ID_Width = $clog2(Num_Of_Masters)
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       M00_AXI_bvalid,
    input  logic [1:0]                 M00_AXI_bresp,
    input  logic [Master_ID_Width-1:0] M00_AXI_bid,
    output logic                       M00_AXI_bready,
    input  logic                       M01_AXI_bvalid,
    input  logic [1:0]                 M01_AXI_bresp,
    input  logic [Master_ID_Width-1:0] M01_AXI_bid,
    output logic                       M01_AXI_bready,
    input  logic                       M02_AXI_bvalid,
    input  logic [1:0]                 M02_AXI_bresp,
    input  logic [Master_ID_Width-1:0] M02_AXI_bid,
    output logic                       M02_AXI_bready,
    input  logic                       M03_AXI_bvalid,
    input  logic [1:0]                 M03_AXI_bresp,
    input  logic [Master_ID_Width-1:0] M03_AXI_bid,
    output logic                       M03_AXI_bready,
    output logic [Master_ID_Width-1:0] Sel_Resp_ID,
    output logic [1:0]                 Sel_Write_Resp,
    output logic                       Sel_Valid,
    input  logic                       Sel_Ready,
    output logic [1:0]                 Granted_Slave
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [3:0] SLAVE_MASK = 4'((5'd1 << Num_Of_Slaves) - 5'd1);

    state_t                     state;
    state_t                     state_next;
    logic [1:0]                 last_grant;
    logic [1:0]                 winner;
    logic                       found;
    logic [3:0]                 req;
    logic                       can_load;
    logic                       slave_hs;
    logic [3:0]                 bready;
    logic [1:0]                 win_resp;
    logic [Master_ID_Width-1:0] win_id;

    assign req      = {M03_AXI_bvalid, M02_AXI_bvalid, M01_AXI_bvalid, M00_AXI_bvalid} & SLAVE_MASK;
    assign can_load = (state == EMPTY) || Sel_Ready;
    assign slave_hs = can_load && found;

    // Search starts just after the last winner so every active port gets a turn
    always_comb begin
        logic [1:0] idx;
        found  = 1'b0;
        winner = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_resp = M00_AXI_bresp;
        win_id   = M00_AXI_bid;
        case (winner)
            2'd1:    begin win_resp = M01_AXI_bresp; win_id = M01_AXI_bid; end
            2'd2:    begin win_resp = M02_AXI_bresp; win_id = M02_AXI_bid; end
            2'd3:    begin win_resp = M03_AXI_bresp; win_id = M03_AXI_bid; end
            default: begin win_resp = M00_AXI_bresp; win_id = M00_AXI_bid; end
        endcase
    end

    // Reset gates bready directly so a slave holding bvalid is never acked while in reset
    always_comb begin
        bready = 4'b0000;
        if (slave_hs && !ARESET) begin
            bready[winner] = 1'b1;
        end
    end

    assign M00_AXI_bready = bready[0];
    assign M01_AXI_bready = bready[1];
    assign M02_AXI_bready = bready[2];
    assign M03_AXI_bready = bready[3];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (slave_hs) state_next = FULL;
            FULL:    if (Sel_Ready && !slave_hs) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign Sel_Valid = (state == FULL);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            Sel_Resp_ID    <= '0;
            Sel_Write_Resp <= 2'b00;
            Granted_Slave  <= 2'd0;
            last_grant     <= 2'd3;
        end else if (slave_hs) begin
            Sel_Resp_ID    <= win_id;
            Sel_Write_Resp <= win_resp;
            Granted_Slave  <= winner;
            last_grant     <= winner;
        end
    end

endmodule

// File: tb/tb_write_resp_channel_arb.sv
// tb/tb_write_resp_channel_arb.sv - directed vector bench for write_resp_channel_arb
module tb_write_resp_channel_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bvalid;
    logic [7:0] bresp;
    logic [7:0] bid;
    logic       rdy;

    logic [3:0] bready;
    logic [1:0] sel_id;
    logic [1:0] sel_resp;
    logic       sel_valid;
    logic [1:0] gs;

    logic [3:0] bready2;
    logic [1:0] sel_id2;
    logic [1:0] sel_resp2;
    logic       sel_valid2;
    logic [1:0] gs2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    write_resp_channel_arb #(.Num_Of_Slaves(4), .Num_Of_Masters(4)) dut (
        .ACLK(clk), .ARESET(rst),
        .M00_AXI_bvalid(bvalid[0]), .M00_AXI_bresp(bresp[1:0]), .M00_AXI_bid(bid[1:0]), .M00_AXI_bready(bready[0]),
        .M01_AXI_bvalid(bvalid[1]), .M01_AXI_bresp(bresp[3:2]), .M01_AXI_bid(bid[3:2]), .M01_AXI_bready(bready[1]),
        .M02_AXI_bvalid(bvalid[2]), .M02_AXI_bresp(bresp[5:4]), .M02_AXI_bid(bid[5:4]), .M02_AXI_bready(bready[2]),
        .M03_AXI_bvalid(bvalid[3]), .M03_AXI_bresp(bresp[7:6]), .M03_AXI_bid(bid[7:6]), .M03_AXI_bready(bready[3]),
        .Sel_Resp_ID(sel_id), .Sel_Write_Resp(sel_resp), .Sel_Valid(sel_valid),
        .Sel_Ready(rdy), .Granted_Slave(gs)
    );

    write_resp_channel_arb #(.Num_Of_Slaves(2), .Num_Of_Masters(4)) dut2 (
        .ACLK(clk), .ARESET(rst),
        .M00_AXI_bvalid(bvalid[0]), .M00_AXI_bresp(bresp[1:0]), .M00_AXI_bid(bid[1:0]), .M00_AXI_bready(bready2[0]),
        .M01_AXI_bvalid(bvalid[1]), .M01_AXI_bresp(bresp[3:2]), .M01_AXI_bid(bid[3:2]), .M01_AXI_bready(bready2[1]),
        .M02_AXI_bvalid(bvalid[2]), .M02_AXI_bresp(bresp[5:4]), .M02_AXI_bid(bid[5:4]), .M02_AXI_bready(bready2[2]),
        .M03_AXI_bvalid(bvalid[3]), .M03_AXI_bresp(bresp[7:6]), .M03_AXI_bid(bid[7:6]), .M03_AXI_bready(bready2[3]),
        .Sel_Resp_ID(sel_id2), .Sel_Write_Resp(sel_resp2), .Sel_Valid(sel_valid2),
        .Sel_Ready(rdy), .Granted_Slave(gs2)
    );

    typedef struct {
        logic [3:0] bvalid;
        logic [7:0] bresp;
        logic [7:0] bid;
        logic       rdy;
        logic [3:0] e_bready;
        logic       e_valid;
        logic       chk;
        logic [1:0] e_id;
        logic [1:0] e_resp;
        logic [1:0] e_gs;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [7:0] r, input logic [7:0] d, input logic s,
                       input logic [3:0] eb, input logic ev, input logic c,
                       input logic [1:0] ei, input logic [1:0] er, input logic [1:0] eg);
        vecs.push_back('{v, r, d, s, eb, ev, c, ei, er, eg});
    endtask

    initial begin
        // contention: slave n carries bresp=n, bid=n
        add(4'hf, 8'he4, 8'he4, 1, 4'b0001, 0, 0, 0, 0, 0);
        add(4'hf, 8'he4, 8'he4, 1, 4'b0010, 1, 1, 0, 0, 0);
        add(4'hf, 8'he4, 8'he4, 1, 4'b0100, 1, 1, 1, 1, 1);
        add(4'hf, 8'he4, 8'he4, 1, 4'b1000, 1, 1, 2, 2, 2);
        add(4'hf, 8'he4, 8'he4, 1, 4'b0001, 1, 1, 3, 3, 3);
        add(4'h0, 8'he4, 8'he4, 1, 4'b0000, 1, 1, 0, 0, 0);
        add(4'h0, 8'he4, 8'he4, 1, 4'b0000, 0, 0, 0, 0, 0);
        // single response from M01: bresp=10, bid=2
        add(4'b0010, 8'h08, 8'h08, 1, 4'b0010, 0, 0, 0, 0, 0);
        add(4'b0000, 8'h08, 8'h08, 1, 4'b0000, 1, 1, 2, 2'b10, 1);
        add(4'b0000, 8'h08, 8'h08, 1, 4'b0000, 0, 0, 0, 0, 0);
        // backpressure: M03 buffered (11, id3), M00 (01, id1) and M02 (10, id0) wait
        add(4'b1000, 8'hc0, 8'hc0, 0, 4'b1000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(4'b0101, 8'h21, 8'h01, 0, 4'b0000, 1, 1, 3, 2'b11, 3);
        add(4'b0101, 8'h21, 8'h01, 1, 4'b0001, 1, 1, 3, 2'b11, 3);
        add(4'b0100, 8'h21, 8'h01, 1, 4'b0100, 1, 1, 1, 2'b01, 0);
        add(4'b0000, 8'h21, 8'h01, 1, 4'b0000, 1, 1, 0, 2'b10, 2);
        add(4'b0000, 8'h21, 8'h01, 1, 4'b0000, 0, 0, 0, 0, 0);

        rst = 1'b1; bvalid = 4'hf; bresp = 8'hff; bid = 8'hff; rdy = 1'b1;
        @(negedge clk); #2;
        check("reset_valid", 8'(sel_valid), 8'd0);
        check("reset_bready", 8'(bready), 8'd0);
        check("reset_id", 8'(sel_id), 8'd0);
        check("reset_resp", 8'(sel_resp), 8'd0);
        check("reset_gs", 8'(gs), 8'd0);
        bvalid = 4'h0;
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            bvalid = vecs[i].bvalid; bresp = vecs[i].bresp; bid = vecs[i].bid; rdy = vecs[i].rdy;
            #2;
            check($sformatf("v%0d_bready", i), 8'(bready), 8'(vecs[i].e_bready));
            check($sformatf("v%0d_valid", i), 8'(sel_valid), 8'(vecs[i].e_valid));
            if (vecs[i].chk) begin
                check($sformatf("v%0d_id", i), 8'(sel_id), 8'(vecs[i].e_id));
                check($sformatf("v%0d_resp", i), 8'(sel_resp), 8'(vecs[i].e_resp));
                check($sformatf("v%0d_gs", i), 8'(gs), 8'(vecs[i].e_gs));
            end
        end

        // reset mid-operation with a stalled response and pending requests
        @(negedge clk);
        bvalid = 4'b0010; bresp = 8'h04; bid = 8'h04; rdy = 1'b0;
        #2 check("mid_load_bready", 8'(bready), 8'b0010);
        @(negedge clk);
        bvalid = 4'b1001;
        #2 check("mid_stall_valid", 8'(sel_valid), 8'd1);
        check("mid_stall_bready", 8'(bready), 8'd0);
        #1 rst = 1'b1;
        #1 check("mid_rst_valid", 8'(sel_valid), 8'd0);
        check("mid_rst_bready", 8'(bready), 8'd0);
        @(negedge clk);
        rst = 1'b0; rdy = 1'b1;
        #2 check("post_rst_bready", 8'(bready), 8'b0001);
        @(negedge clk);
        bvalid = 4'b0000;
        #2 check("post_rst_valid", 8'(sel_valid), 8'd1);
        check("post_rst_gs", 8'(gs), 8'd0);
        repeat (2) @(negedge clk);

        // masking on the two-slave instance
        bvalid = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            check($sformatf("mask%0d_bready", i), 8'(bready2), 8'd0);
            check($sformatf("mask%0d_valid", i), 8'(sel_valid2), 8'd0);
        end
        bvalid = 4'b1010;
        #1 check("mask_m01_bready", 8'(bready2), 8'b0010);
        @(negedge clk);
        bvalid = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/write_resp_channel_arb.md
Name: write_resp_channel_arb

Overview:
Slave-side write-response (B channel) arbiter/encoder for the AXI interconnect. It collects B responses from up to four downstream slave ports and arbitrates between them round-robin. It registers the winner into a single-entry output stage and presents it as Sel_Resp_ID / Sel_Write_Resp / Sel_Valid to the write-response decoder, which routes it to the owning master. It back-pressures slaves via bready until the selected master accepts the response.

Parameters:
Num_Of_Slaves, 4, number of active slave ports (1..4); ports with index >= Num_Of_Slaves are masked (never granted, bready held 0)
Num_Of_Masters, 4, number of masters on the interconnect
Master_ID_Width, $clog2(Num_Of_Masters), width of the master-ID field carried in bid

Ports:
ACLK  input  1  clock, all state updates on rising edge
ARESET  input  1  asynchronous, active-high reset
M00_AXI_bvalid / M01_AXI_bvalid / M02_AXI_bvalid / M03_AXI_bvalid  input  1 each  response valid from slave port n
M00_AXI_bresp / M01_AXI_bresp / M02_AXI_bresp / M03_AXI_bresp  input  2 each  write response from slave port n
M00_AXI_bid / M01_AXI_bid / M02_AXI_bid / M03_AXI_bid  input  Master_ID_Width each  ID of the master that owns the response
M00_AXI_bready / M01_AXI_bready / M02_AXI_bready / M03_AXI_bready  output  1 each  response accepted from slave port n
Sel_Resp_ID  output  Master_ID_Width  registered master ID of the buffered response
Sel_Write_Resp  output  2  registered bresp of the buffered response
Sel_Valid  output  1  output stage holds a valid response
Sel_Ready  input  1  selected master's bready, muxed downstream
Granted_Slave  output  2  slave index of the buffered response (debug/monitor)

Behaviour:
- Reset (asynchronous, immediate): Sel_Valid=0, Sel_Resp_ID=0, Sel_Write_Resp=2'b00, Granted_Slave=0, last_grant=3 (slave 0 wins first), all bready=0. A response held at reset is discarded.
- Output stage is one register entry. can_load = !Sel_Valid || Sel_Ready.
- Arbitration is combinational each cycle over masked bvalid. Search order is last_grant+1, +2, +3, +4 (mod 4). The first active request wins.
- bready[n] = can_load && (winner == n) && bvalid[n]. At most one bready is high per cycle. bready depends on Sel_Ready combinationally; no other combinational path from inputs to outputs.
- On a slave handshake (bvalid & bready) in cycle N:
  - at the edge, load Sel_Resp_ID=bid, Sel_Write_Resp=bresp, Granted_Slave=n, last_grant=n, Sel_Valid=1
  - the response is visible from cycle N+1 (latency 1)
- Master handshake: Sel_Valid && Sel_Ready at an edge.
  - With a simultaneous new slave handshake, the register reloads and Sel_Valid stays 1. This gives full throughput of one response per cycle.
  - Otherwise Sel_Valid goes 0.
- While Sel_Valid && !Sel_Ready:
  - Sel_Resp_ID, Sel_Write_Resp and Granted_Slave hold stable
  - all bready are 0
  - last_grant is unchanged
- last_grant updates only on a slave handshake, never on idle cycles.
- bresp and bid pass through unmodified; no ID range checking is done. bid is not rewritten, because the decoder uses it directly.
- FSM, 2 states encoded by Sel_Valid:
  - EMPTY -> FULL on slave handshake
  - FULL -> EMPTY on master handshake with no slave handshake
  - FULL -> FULL on stall, or on master handshake with slave handshake
- Slaves must hold bvalid/bresp/bid until bready. A slave dropping bvalid without a handshake is outside the protocol; the block simply re-arbitrates.

Test Plan:
- Single response: reset, then M01 bvalid=1, bresp=2'b10, bid=2 with Sel_Ready=1 -> M01 bready=1 in the same cycle; next cycle Sel_Valid=1, Sel_Write_Resp=2'b10, Sel_Resp_ID=2, Granted_Slave=1; following cycle Sel_Valid=0.
- Contention: all four bvalid held with Sel_Ready=1 -> grants 0,1,2,3,0 on consecutive cycles; Sel_Valid continuously 1 from the second cycle.
- Backpressure: buffer a response (bresp=2'b11, bid=3) with Sel_Ready=0 for 5 cycles while M00 and M02 request -> outputs stable, all bready=0; Sel_Ready=1 -> M00 accepted in that same cycle, new data next cycle.
- Masking: Num_Of_Slaves=2, M02/M03 bvalid=1 -> M02/M03 bready never asserted, Sel_Valid stays 0.
- Reset mid-operation: Sel_Valid=1 held, assert ARESET between edges -> Sel_Valid and all bready drop immediately. After release, M03 and M00 requesting -> M00 is granted first.
